fifo_sync_thresh: RTL
=====================

FIFO_SYNC_THRESH -- requirements
Module: fifo_sync_thresh

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 4, depth DEPTH = 2**ADDR_BITS words.
REQ-003 SHALL have parameter AF_THRESH, default 12, almost-full level in words (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 4, almost-empty level in words (0..DEPTH-1).
REQ-005 SHALL use one clock, clk_i; reset is synchronous and active-high on reset_i.
REQ-006 SHALL have ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous clear of contents and error flags.
- data_in  in  DATA_WIDTH  write data.
- w_en  in  1  write request.
- r_en  in  1  read request (read acknowledge in FWFT).
- data_out  out  DATA_WIDTH  read data.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- fill_count  out  ADDR_BITS+1  words stored, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-007 Write accepted on an edge iff w_en=1, fifo_full=0, flush_i=0: data_in stored at w_ptr, w_ptr+1.
REQ-008 Read accepted on an edge iff r_en=1, fifo_empty=0, flush_i=0: r_ptr+1.
REQ-009 Pointers ADDR_BITS wide, wrap DEPTH-1 -> 0 with no extra logic.
REQ-010 fill_count registered: +1 write only, -1 read only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
REQ-011 All status flags derive combinationally from registered fill_count; valid the cycle after the causing edge.
REQ-012 Full + w_en + r_en: only read accepted; count DEPTH -> DEPTH-1; overflow set.
REQ-013 Empty + w_en + r_en: only write accepted; count 0 -> 1; underflow set.
REQ-014 Rejected write: memory, w_ptr unchanged; overflow set at edge, held until reset/flush.
REQ-015 Rejected read: r_ptr, data_out unchanged; underflow set at edge, held until reset/flush.
REQ-016 flush_i=1: w_ptr, r_ptr, fill_count, overflow, underflow := 0; data_out := 0 (standard mode); same-cycle w_en/r_en ignored, no error flags.
REQ-017 Memory contents not cleared by reset or flush.

Reset
REQ-018 reset_i=1 at edge: pointers, fill_count, overflow, underflow, data_out := 0; fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0 next cycle.
REQ-019 reset_i has priority over flush_i, w_en, r_en; mid-operation reset discards all content and same-cycle requests.

Configuration
REQ-020 Macro FIFO_SYNC_FWFT_EN selects read mode.
REQ-021 Undefined (standard): data_out registered, loads mem[r_ptr] on accepted-read edge, 1-cycle latency, holds otherwise.
REQ-022 Defined (FWFT): data_out = mem[r_ptr] combinationally whenever fifo_empty=0, 0 when empty; first word visible the cycle after its write edge; r_en pops.

Structure
REQ-023 Package fifo_sync_pkg holds default DATA_WIDTH, ADDR_BITS, AF_THRESH, AE_THRESH constants and the fill-count width function.
REQ-024 Storage in sub-module fifo_sync_mem: DEPTH x DATA_WIDTH array, one synchronous write port, one asynchronous read port; control and flags in fifo_sync_thresh.

Verification (DEPTH=16, AF=12, AE=4)
REQ-025 Reset, 16 writes 0x00..0x0F, no reads -> fill_count 16, fifo_full=1 after 16th edge, almost_full from 12th, almost_empty clears at 5th.
REQ-026 Full, w_en=1 with 0xAA -> overflow=1, count 16, 0xAA never read; 16 reads return 0x00..0x0F in order.
REQ-027 Empty, r_en=1 -> underflow=1, data_out unchanged, count 0; flush_i one cycle -> underflow=0.
REQ-028 Count 8, w_en=r_en=1 for 40 cycles -> count stays 8, pointers wrap, data in order; at full, both -> count 15; at empty, both -> count 1.
REQ-029 Count 10, reset_i high one cycle with w_en=1 -> count 0, fifo_empty=1, flags 0, written word absent.
REQ-030 Both modes: write 0x5A to empty -> FWFT data_out=0x5A next cycle without r_en; standard data_out=0x5A one cycle after r_en accepted.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared defaults, fill-count width helper and status flag bundle for the
// thresholded synchronous FIFO.
package fifo_sync_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 4;
    localparam int DEF_AF_THRESH  = 12;
    localparam int DEF_AE_THRESH  = 4;

    // The count must represent 0..DEPTH inclusive, so one bit wider than an address.
    function automatic int fill_count_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync_thresh: one synchronous write port, one
// asynchronous read port. Contents are never cleared.
module fifo_sync_mem
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  clk_i,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_BITS-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_thresh.sv
// Synchronous FIFO with fill count, almost-full/empty thresholds and sticky
// overflow/underflow flags. Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads.
module fifo_sync_thresh
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_en,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int             CW      = fill_count_width(ADDR_BITS);
    localparam int             DEPTH   = 2 ** ADDR_BITS;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]  AE_C    = CW'(AE_THRESH);

    logic [ADDR_BITS-1:0]  r_wptr;
    logic [ADDR_BITS-1:0]  r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    fifo_flags_t           w_flags;

    // Every flag comes from the registered count, so flags lag the causing edge by one cycle.
    assign w_flags.full         = (r_count == DEPTH_C);
    assign w_flags.empty        = (r_count == '0);
    assign w_flags.almost_full  = (r_count >= AF_C);
    assign w_flags.almost_empty = (r_count <= AE_C);

    // Handshake: a write is taken when w_en=1 and not full, a read when r_en=1
    // and not empty; flush_i (and reset_i above it) cancels both that cycle.
    assign w_wr_acc = w_en && !w_flags.full  && !flush_i;
    assign w_rd_acc = r_en && !w_flags.empty && !flush_i;

    fifo_sync_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_mem (
        .clk_i   (clk_i),
        .i_we    (w_wr_acc && !reset_i),
        .i_waddr (r_wptr),
        .i_wdata (data_in),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_en && w_flags.full) begin
                r_overflow <= 1'b1;
            end
            if (r_en && w_flags.empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    assign data_out = w_flags.empty ? '0 : w_rdata;
`else
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= w_rdata;
        end
    end

    assign data_out = r_dout;
`endif

    assign fifo_full    = w_flags.full;
    assign fifo_empty   = w_flags.empty;
    assign almost_full  = w_flags.almost_full;
    assign almost_empty = w_flags.almost_empty;
    assign fill_count   = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
